// File: rtl/uart_frame_receiver.sv
// Host-to-FPGA frame decoder: SOF, TYPE, payload, XOR checksum.
// Board loads commit atomically; commands publish as a one-cycle strobe.
module uart_frame_receiver #(
    parameter logic [7:0]  SOF_BYTE       = 8'hAA,
    parameter logic [7:0]  TYPE_BOARD     = 8'h01,
    parameter logic [7:0]  TYPE_CMD       = 8'h02,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         rx_error,
    output logic [323:0] board_out,
    output logic         board_valid,
    output logic         cmd_valid,
    output logic [7:0]   cmd_code,
    output logic [7:0]   cmd_arg,
    output logic         frame_error,
    output logic         busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_WAIT_SOF,
        S_TYPE,
        S_PAYLOAD,
        S_CHECK
    } state_e;

    state_e         state_q, state_d;
    logic           is_board_q, is_board_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [7:0]     chk_q, chk_d;
    logic           bad_q, bad_d;
    logic [323:0]   stage_q, stage_d;
    logic [7:0]     code_stg_q, code_stg_d;
    logic [7:0]     arg_stg_q, arg_stg_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [TW-1:0]  tmo_inc;
    logic [323:0]   board_q, board_d;
    logic           bv_q, bv_d;
    logic           cv_q, cv_d;
    logic [7:0]     code_q, code_d;
    logic [7:0]     arg_q, arg_d;
    logic           ferr_q, ferr_d;
    logic [6:0]     last_idx;

    assign tmo_inc  = tmo_q + TW'(1);
    assign last_idx = is_board_q ? 7'd80 : 7'd1;

    always_comb begin
        state_d    = state_q;
        is_board_d = is_board_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        bad_d      = bad_q;
        stage_d    = stage_q;
        code_stg_d = code_stg_q;
        arg_stg_d  = arg_stg_q;
        tmo_d      = tmo_q;
        board_d    = board_q;
        code_d     = code_q;
        arg_d      = arg_q;
        bv_d       = 1'b0;
        cv_d       = 1'b0;
        ferr_d     = 1'b0;

        if (state_q == S_WAIT_SOF) begin
            tmo_d = '0;
            if (rx_valid && rx_data == SOF_BYTE) begin
                state_d = S_TYPE;
            end
        end else if (rx_error) begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_SOF;
            tmo_d   = '0;
            stage_d = '0;
        end else if (!rx_valid) begin
            // A byte arriving in the expiry cycle takes the other branch.
            if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
                ferr_d  = 1'b1;
                state_d = S_WAIT_SOF;
                tmo_d   = '0;
                stage_d = '0;
            end else begin
                tmo_d = tmo_inc;
            end
        end else begin
            tmo_d = '0;
            unique case (state_q)
                S_TYPE: begin
                    cnt_d = '0;
                    chk_d = rx_data;
                    bad_d = 1'b0;
                    if (rx_data == TYPE_BOARD) begin
                        is_board_d = 1'b1;
                        state_d    = S_PAYLOAD;
                    end else if (rx_data == TYPE_CMD) begin
                        is_board_d = 1'b0;
                        state_d    = S_PAYLOAD;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_SOF;
                    end
                end
                S_PAYLOAD: begin
                    chk_d = chk_q ^ rx_data;
                    cnt_d = cnt_q + 7'd1;
                    if (is_board_q) begin
                        stage_d[{cnt_q, 2'b00} +: 4] = rx_data[3:0];
                        if (rx_data > 8'h09) begin
                            bad_d = 1'b1;
                        end
                    end else if (cnt_q == 7'd0) begin
                        code_stg_d = rx_data;
                    end else begin
                        arg_stg_d = rx_data;
                    end
                    if (cnt_q == last_idx) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    state_d = S_WAIT_SOF;
                    if (rx_data == chk_q && !bad_q) begin
                        if (is_board_q) begin
                            board_d = stage_q;
                            bv_d    = 1'b1;
                        end else begin
                            code_d = code_stg_q;
                            arg_d  = arg_stg_q;
                            cv_d   = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = S_WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_WAIT_SOF;
            is_board_q <= 1'b0;
            cnt_q      <= '0;
            chk_q      <= '0;
            bad_q      <= 1'b0;
            stage_q    <= '0;
            code_stg_q <= '0;
            arg_stg_q  <= '0;
            tmo_q      <= '0;
            board_q    <= '0;
            bv_q       <= 1'b0;
            cv_q       <= 1'b0;
            code_q     <= '0;
            arg_q      <= '0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_board_q <= is_board_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            bad_q      <= bad_d;
            stage_q    <= stage_d;
            code_stg_q <= code_stg_d;
            arg_stg_q  <= arg_stg_d;
            tmo_q      <= tmo_d;
            board_q    <= board_d;
            bv_q       <= bv_d;
            cv_q       <= cv_d;
            code_q     <= code_d;
            arg_q      <= arg_d;
            ferr_q     <= ferr_d;
        end
    end

    assign board_out   = board_q;
    assign board_valid = bv_q;
    assign cmd_valid   = cv_q;
    assign cmd_code    = code_q;
    assign cmd_arg     = arg_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != S_WAIT_SOF);

endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
- Receive-side counterpart of the game's UART transmit path: consumes bytes from the UART RX core and decodes host-to-FPGA frames.
- Two frame types: a full-board load (81 cells) and a 2-byte game command.
- Board updates are published atomically and only on a good checksum. Commands are published as a single-cycle strobe for the game FSM.

Parameters:
- SOF_BYTE, 8'hAA, start-of-frame marker.
- TYPE_BOARD, 8'h01, type code for a board frame (81 payload bytes).
- TYPE_CMD, 8'h02, type code for a command frame (2 payload bytes).
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame before it is aborted.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- rx_error  in  1  one-cycle strobe, UART framing/parity error on the current byte
- board_out  out  324  committed board; cell i at bits [4i+3:4i]
- board_valid  out  1  one-cycle pulse, board_out just updated
- cmd_valid  out  1  one-cycle pulse, cmd_code/cmd_arg just updated
- cmd_code  out  8  last accepted command code
- cmd_arg  out  8  last accepted command argument
- frame_error  out  1  one-cycle pulse, frame rejected
- busy  out  1  high while a frame is in progress (state != S_WAIT_SOF)

Behaviour:
- Reset values: all outputs 0; state S_WAIT_SOF; staging register, checksum, byte counter and timeout counter all 0.
- Frame format: SOF, TYPE, payload, CHK. CHK = XOR of TYPE and all payload bytes; SOF is excluded from CHK.
- S_WAIT_SOF:
  - rx_valid with rx_data == SOF_BYTE: go to S_TYPE.
  - Any other byte: ignored; no error pulse.
- S_TYPE:
  - TYPE_BOARD: set len=81, chk=TYPE, go to S_PAYLOAD.
  - TYPE_CMD: set len=2, chk=TYPE, go to S_PAYLOAD.
  - Any other value: frame_error pulse, go to S_WAIT_SOF.
- S_PAYLOAD:
  - Each rx_valid: chk ^= byte; store the byte; count++. Go to S_CHECK after byte len-1.
  - Board payload byte k is written to staging[4k+3:4k] as rx_data[3:0].
  - A board byte > 8'h09 sets a sticky bad_cell flag; the byte is still stored and counted.
  - Cmd payload: byte 0 is staged as code, byte 1 as arg.
  - A SOF-valued byte inside the payload is plain data; there is no resync.
- S_CHECK, on rx_valid:
  - Accept if the byte equals chk and bad_cell is 0.
    - Board frame: board_out <= staging; board_valid pulse.
    - Cmd frame: cmd_code/cmd_arg updated; cmd_valid pulse.
  - Otherwise: frame_error pulse; board_out, cmd_code and cmd_arg unchanged.
  - Return to S_WAIT_SOF in either case.
- Latency: the valid or error pulse is high exactly in the cycle after the CHK byte's rx_valid cycle.
  - The next frame's SOF may arrive in that same cycle and must be accepted.
- Abort conditions apply in any state other than S_WAIT_SOF:
  - rx_error pulse: frame_error pulse, go to S_WAIT_SOF, discard staging. Takes priority over a simultaneous rx_valid.
  - rx_error in S_WAIT_SOF: ignored.
- Timeout:
  - Counter clears on every rx_valid, counts while busy, and is held at 0 in S_WAIT_SOF.
  - When it reaches TIMEOUT_CYCLES: frame_error pulse, go to S_WAIT_SOF.
  - rx_valid in the expiry cycle wins: the byte is accepted and the counter cleared.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Mutual exclusion: board_valid, cmd_valid and frame_error are never high in the same cycle.
- Staging isolation: board_out changes only on an accepted board frame. A partial or rejected frame never alters any committed output.
- Reset mid-frame: returns to S_WAIT_SOF on the next edge with all outputs at reset values, including board_out = 0.
- No backpressure: the RX core cannot be stalled, so every rx_valid is consumed in its cycle.

Test Plan:
- Board load: AA 01, then bytes 00..08 repeated 9 times (cell k = k mod 9), then correct CHK → one board_valid pulse; board_out[3:0]=0, [7:4]=1, [323:320]=8; busy low afterwards.
- Command: AA 02 05 03 CHK=01^05^03=07 → cmd_valid pulse one cycle after CHK; cmd_code=8'h05, cmd_arg=8'h03; board_out unchanged.
- Bad checksum: the same command frame with CHK=08 → frame_error pulse; cmd_code/cmd_arg keep their previous values; a following good frame is accepted normally.
- Bad cell and unknown type:
  - Board frame with cell 40 = 8'h0A and a correct XOR CHK → frame_error; board_out unchanged.
  - AA 07 → frame_error one cycle after TYPE.
  - Leading garbage 55 13 before SOF → no pulse.
- Abort paths, each followed by a back-to-back good frame that must still decode:
  - TIMEOUT_CYCLES=100 override: AA 02 05, then 100 idle cycles → frame_error; rx_valid on exactly cycle 100 instead → no error.
  - rx_error mid-payload → frame_error.
- Reset mid-board-frame after 40 payload bytes → all outputs 0, busy 0; a full good frame afterwards loads correctly.
